matrix_alu_gen: RTL

Parametrised matrix arithmetic engine for the CalcKit matrix store. Reads operands element-by-element from any two storage slots through a combinational read port, computes ADD/SUB/MUL/SCA/TRA/HAD (Hadamard), and writes the result plus its dimensions to a caller-selected destination slot. Adds configurable element/index widths, saturating or wrapping arithmetic, overflow reporting, slot-alias checks and coded errors. It sits between the menu/control FSM and the matrix memory.

---
 rtl/matrix_alu_gen.sv | 324 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/matrix_alu_gen.sv
// Matrix arithmetic engine: reads two operand slots element by element and writes
// ADD/SUB/MUL/SCA/TRA/HAD results plus dimensions to a destination slot.
module matrix_alu_gen #(
    parameter int DW     = 16,
    parameter int DIM_W  = 3,
    parameter int SLOT_W = 2,
    parameter int ACC_W  = 2*DW + DIM_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        opcode,
    input  logic              sat_en,
    input  logic [DW-1:0]     scalar_val,
    input  logic [SLOT_W-1:0] slot_a,
    input  logic [SLOT_W-1:0] slot_b,
    input  logic [SLOT_W-1:0] slot_dst,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic              ovf,
    output logic [SLOT_W-1:0] mem_rd_slot,
    output logic [DIM_W-1:0]  mem_rd_row,
    output logic [DIM_W-1:0]  mem_rd_col,
    input  logic [DW-1:0]     mem_rd_data,
    input  logic [DIM_W-1:0]  mem_dim_m,
    input  logic [DIM_W-1:0]  mem_dim_n,
    output logic [SLOT_W-1:0] mem_wr_slot,
    output logic [DIM_W-1:0]  mem_wr_row,
    output logic [DIM_W-1:0]  mem_wr_col,
    output logic [DW-1:0]     mem_wr_data,
    output logic              mem_wr_we,
    output logic [DIM_W-1:0]  mem_res_m,
    output logic [DIM_W-1:0]  mem_res_n,
    output logic              mem_dim_we
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_SCA = 3'b011;
    localparam logic [2:0] OP_TRA = 3'b100;
    localparam logic [2:0] OP_HAD = 3'b101;

    typedef enum logic [3:0] {
        S_IDLE, S_DIM_A, S_DIM_B, S_CHECK, S_INIT,
        S_RD_A, S_RD_B, S_MAC, S_WRITE, S_DONE, S_ERROR
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           op_q, op_d;
    logic                 sat_q, sat_d;
    logic [DW-1:0]        scalar_q, scalar_d;
    logic [SLOT_W-1:0]    slot_a_q, slot_a_d, slot_b_q, slot_b_d, slot_dst_q, slot_dst_d;
    logic [DIM_W-1:0]     ma_q, ma_d, na_q, na_d, mb_q, mb_d, nb_q, nb_d;
    logic [DIM_W-1:0]     res_m_q, res_m_d, res_n_q, res_n_d;
    logic [DIM_W-1:0]     i_q, i_d, j_q, j_d, k_q, k_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [DW-1:0]        a_val_q, a_val_d, b_val_q, b_val_d;
    logic [DIM_W-1:0]     wr_row_q, wr_row_d, wr_col_q, wr_col_d;
    logic [DW-1:0]        wr_data_q, wr_data_d;
    logic                 wr_we_q, wr_we_d, dim_we_q, dim_we_d;
    logic [1:0]           err_code_q, err_code_d;
    logic                 ovf_q, ovf_d;

    logic signed [ACC_W-1:0] a_ext, b_ext, s_ext, rd_ext, full, trunc_ext, mac_sum;
    logic                    elem_ovf;
    logic [DW-1:0]           elem_data;
    logic                    op_illegal, op_two_src, alias_err, dim_err;

    // All arithmetic is done at ACC_W; the narrower widths of ADD/SUB/SCA/HAD are subsets.
    always_comb begin
        a_ext  = {{(ACC_W-DW){a_val_q[DW-1]}}, a_val_q};
        b_ext  = {{(ACC_W-DW){b_val_q[DW-1]}}, b_val_q};
        s_ext  = {{(ACC_W-DW){scalar_q[DW-1]}}, scalar_q};
        rd_ext = {{(ACC_W-DW){mem_rd_data[DW-1]}}, mem_rd_data};
        mac_sum = acc_q + a_ext * rd_ext;
        case (op_q)
            OP_ADD:  full = a_ext + b_ext;
            OP_SUB:  full = a_ext - b_ext;
            OP_MUL:  full = acc_q;
            OP_SCA:  full = a_ext * s_ext;
            OP_HAD:  full = a_ext * b_ext;
            default: full = a_ext;
        endcase
        trunc_ext = {{(ACC_W-DW){full[DW-1]}}, full[DW-1:0]};
        elem_ovf  = (trunc_ext != full);
        if (elem_ovf && sat_q)
            elem_data = full[ACC_W-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        else
            elem_data = full[DW-1:0];
    end

    always_comb begin
        op_illegal = (op_q[2:1] == 2'b11);
        op_two_src = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_MUL) || (op_q == OP_HAD);
        alias_err  = (slot_dst_q == slot_a_q) || (op_two_src && (slot_dst_q == slot_b_q));
        if (op_q == OP_MUL)
            dim_err = (ma_q == '0) || (na_q == '0) || (mb_q == '0) || (nb_q == '0) || (na_q != mb_q);
        else if (op_two_src)
            dim_err = (ma_q == '0) || (na_q == '0) || (ma_q != mb_q) || (na_q != nb_q);
        else
            dim_err = (ma_q == '0) || (na_q == '0);
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        sat_d      = sat_q;
        scalar_d   = scalar_q;
        slot_a_d   = slot_a_q;
        slot_b_d   = slot_b_q;
        slot_dst_d = slot_dst_q;
        ma_d       = ma_q;
        na_d       = na_q;
        mb_d       = mb_q;
        nb_d       = nb_q;
        res_m_d    = res_m_q;
        res_n_d    = res_n_q;
        i_d        = i_q;
        j_d        = j_q;
        k_d        = k_q;
        acc_d      = acc_q;
        a_val_d    = a_val_q;
        b_val_d    = b_val_q;
        wr_row_d   = wr_row_q;
        wr_col_d   = wr_col_q;
        wr_data_d  = wr_data_q;
        wr_we_d    = 1'b0;
        dim_we_d   = 1'b0;
        err_code_d = err_code_q;
        ovf_d      = ovf_q;
        mem_rd_slot = slot_a_q;
        mem_rd_row  = '0;
        mem_rd_col  = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d       = opcode;
                    sat_d      = sat_en;
                    scalar_d   = scalar_val;
                    slot_a_d   = slot_a;
                    slot_b_d   = slot_b;
                    slot_dst_d = slot_dst;
                    err_code_d = '0;
                    ovf_d      = 1'b0;
                    state_d    = S_DIM_A;
                end
            end
            S_DIM_A: begin
                ma_d    = mem_dim_m;
                na_d    = mem_dim_n;
                state_d = S_DIM_B;
            end
            S_DIM_B: begin
                mem_rd_slot = slot_b_q;
                mb_d    = mem_dim_m;
                nb_d    = mem_dim_n;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (op_illegal) begin
                    err_code_d = 2'b10;
                    state_d    = S_ERROR;
                end else if (alias_err) begin
                    err_code_d = 2'b11;
                    state_d    = S_ERROR;
                end else if (dim_err) begin
                    err_code_d = 2'b01;
                    state_d    = S_ERROR;
                end else begin
                    res_m_d = (op_q == OP_TRA) ? na_q : ma_q;
                    res_n_d = (op_q == OP_MUL) ? nb_q : (op_q == OP_TRA) ? ma_q : na_q;
                    state_d = S_INIT;
                end
            end
            S_INIT: begin
                dim_we_d = 1'b1;
                i_d      = '0;
                j_d      = '0;
                k_d      = '0;
                acc_d    = '0;
                state_d  = S_RD_A;
            end
            S_RD_A: begin
                // TRA reads transposed, MUL walks A along the shared k index
                if (op_q == OP_TRA) begin
                    mem_rd_row = j_q;
                    mem_rd_col = i_q;
                end else if (op_q == OP_MUL) begin
                    mem_rd_row = i_q;
                    mem_rd_col = k_q;
                end else begin
                    mem_rd_row = i_q;
                    mem_rd_col = j_q;
                end
                a_val_d = mem_rd_data;
                if (op_q == OP_MUL)
                    state_d = S_MAC;
                else if ((op_q == OP_SCA) || (op_q == OP_TRA))
                    state_d = S_WRITE;
                else
                    state_d = S_RD_B;
            end
            S_RD_B: begin
                mem_rd_slot = slot_b_q;
                mem_rd_row  = i_q;
                mem_rd_col  = j_q;
                b_val_d     = mem_rd_data;
                state_d     = S_WRITE;
            end
            S_MAC: begin
                mem_rd_slot = slot_b_q;
                mem_rd_row  = k_q;
                mem_rd_col  = j_q;
                acc_d       = mac_sum;
                if (k_q == na_q - DIM_W'(1)) begin
                    state_d = S_WRITE;
                end else begin
                    k_d     = k_q + DIM_W'(1);
                    state_d = S_RD_A;
                end
            end
            S_WRITE: begin
                wr_we_d   = 1'b1;
                wr_row_d  = i_q;
                wr_col_d  = j_q;
                wr_data_d = elem_data;
                if (elem_ovf)
                    ovf_d = 1'b1;
                acc_d   = '0;
                k_d     = '0;
                state_d = S_RD_A;
                if (j_q == res_n_q - DIM_W'(1)) begin
                    j_d = '0;
                    if (i_q == res_m_q - DIM_W'(1))
                        state_d = S_DONE;
                    else
                        i_d = i_q + DIM_W'(1);
                end else begin
                    j_d = j_q + DIM_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERROR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            sat_q      <= 1'b0;
            scalar_q   <= '0;
            slot_a_q   <= '0;
            slot_b_q   <= '0;
            slot_dst_q <= '0;
            ma_q       <= '0;
            na_q       <= '0;
            mb_q       <= '0;
            nb_q       <= '0;
            res_m_q    <= '0;
            res_n_q    <= '0;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            acc_q      <= '0;
            a_val_q    <= '0;
            b_val_q    <= '0;
            wr_row_q   <= '0;
            wr_col_q   <= '0;
            wr_data_q  <= '0;
            wr_we_q    <= 1'b0;
            dim_we_q   <= 1'b0;
            err_code_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            sat_q      <= sat_d;
            scalar_q   <= scalar_d;
            slot_a_q   <= slot_a_d;
            slot_b_q   <= slot_b_d;
            slot_dst_q <= slot_dst_d;
            ma_q       <= ma_d;
            na_q       <= na_d;
            mb_q       <= mb_d;
            nb_q       <= nb_d;
            res_m_q    <= res_m_d;
            res_n_q    <= res_n_d;
            i_q        <= i_d;
            j_q        <= j_d;
            k_q        <= k_d;
            acc_q      <= acc_d;
            a_val_q    <= a_val_d;
            b_val_q    <= b_val_d;
            wr_row_q   <= wr_row_d;
            wr_col_q   <= wr_col_d;
            wr_data_q  <= wr_data_d;
            wr_we_q    <= wr_we_d;
            dim_we_q   <= dim_we_d;
            err_code_q <= err_code_d;
            ovf_q      <= ovf_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign error       = (state_q == S_ERROR);
    assign err_code    = err_code_q;
    assign ovf         = ovf_q;
    assign mem_wr_slot = slot_dst_q;
    assign mem_wr_row  = wr_row_q;
    assign mem_wr_col  = wr_col_q;
    assign mem_wr_data = wr_data_q;
    assign mem_wr_we   = wr_we_q;
    assign mem_res_m   = res_m_q;
    assign mem_res_n   = res_n_q;
    assign mem_dim_we  = dim_we_q;

endmodule
